fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: Fetch_Queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of fetch-pack entries (power of two, >=2).
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port io_i_flush  input  1  redirect: discard all queued and incoming packs.
REQ-005 SHALL have port io_i_fetch_pack_valid  input  1  upstream pack present.
REQ-006 SHALL have port io_i_fetch_pack_ready  output  1  queue can accept a pack this cycle.
REQ-007 SHALL have input ports io_i_fetch_pack_bits_{valids_0 1, valids_1 1, pc 64, insts_0 32, insts_1 32, branch_predict_pack_valid 1, _target 64, _branch_type 4, _select 1, _taken 1}, carrying one fetch pack.
REQ-008 SHALL have port io_o_fetch_pack_valid  output  1  head entry present for decode.
REQ-009 SHALL have port io_o_fetch_pack_ready  input  1  decode consumes head this cycle.
REQ-010 SHALL have output ports io_o_fetch_pack_bits_* mirroring REQ-007 fields and widths, presenting the head entry.

Function
REQ-011 SHALL store each pack as one 201-bit entry in a DEPTH-deep circular buffer with head pointer, tail pointer (log2(DEPTH) bits, natural wrap) and count (log2(DEPTH)+1 bits).
REQ-012 SHALL drive io_i_fetch_pack_ready = (count != DEPTH); no same-cycle pass-through when full.
REQ-013 SHALL enqueue when io_i_fetch_pack_valid & io_i_fetch_pack_ready & ~io_i_flush: write entry[tail], tail+1.
REQ-014 SHALL drive io_o_fetch_pack_valid = (count != 0) and bits = entry[head], directly from storage.
REQ-015 SHALL dequeue when io_o_fetch_pack_valid & io_o_fetch_pack_ready & ~io_i_flush: head+1.
REQ-016 SHALL update count +1 on enqueue only, -1 on dequeue only, unchanged on both or neither.
REQ-017 SHALL allow simultaneous enqueue and dequeue at any count 1..DEPTH-1; when full, only dequeue occurs that cycle, ready rises next cycle.
REQ-018 SHALL have enqueue-to-output latency of exactly one cycle: pack enqueued into empty queue in cycle N is valid at output in cycle N+1.
REQ-019 SHALL, on io_i_flush, set head, tail, count to 0 next cycle, dropping any concurrent enqueue and dequeue; flush has priority over all other events.
REQ-020 SHALL keep io_i_fetch_pack_ready as REQ-012 during flush (input dropped, not stalled).
REQ-021 SHALL preserve all pack fields bit-exact, including packs with valids_0=0 (pc low bits are already aligned upstream).
REQ-022 SHALL hold output bits stable while io_o_fetch_pack_valid=1 and io_o_fetch_pack_ready=0.

Reset
REQ-023 SHALL, on reset assertion, immediately clear head, tail, count to 0 and entry storage to 0, independent of clock.
REQ-024 SHALL present io_o_fetch_pack_valid=0, io_i_fetch_pack_ready=1, all output bits 0 while in reset.
REQ-025 SHALL discard any in-flight handshake when reset asserts mid-operation; first post-reset cycle behaves as empty queue.

Structure
REQ-026 SHALL take fetch-pack field widths (pc 64, inst 32, branch_type 4) and the pack/branch-predict-pack record layout from the shared core package used by fetch and decode.
REQ-027 SHALL be flat: storage, pointers and count inline; no sub-module.

Verification
REQ-028 SHALL cover: reset, then one pack pc=0x80000000, insts 0x00000013/0x00100093 -> output valid next cycle with identical fields; ready=1 throughout.
REQ-029 SHALL cover: 4 enqueues with io_o_fetch_pack_ready=0 -> count=4, io_i_fetch_pack_ready=0, 5th pack held upstream; then dequeue 4 -> packs in FIFO order.
REQ-030 SHALL cover: full queue, dequeue and offered enqueue same cycle -> only dequeue, count 3, ready=1 next cycle, then enqueue lands at wrapped tail.
REQ-031 SHALL cover: count=2, flush with simultaneous enqueue and dequeue -> next cycle count=0, output valid=0, dropped pack never appears.
REQ-032 SHALL cover: 1000 cycles random valid/ready against scoreboard -> no loss, duplication or reorder; pointer wrap exercised >=100 times.
REQ-033 SHALL cover: reset asserted asynchronously mid-burst with count=3 -> output valid drops before next clock edge, queue empty after release.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared fetch/decode record layout: field widths and the fetch-pack /
// branch-predict-pack structures carried between the two stages.
package fetch_queue_pkg;

    localparam int XLEN      = 64;
    localparam int INST_W    = 32;
    localparam int BR_TYPE_W = 4;

    typedef struct packed {
        logic                 valid;
        logic [XLEN-1:0]      target;
        logic [BR_TYPE_W-1:0] branch_type;
        logic                 select;
        logic                 taken;
    } bp_pack_t;

    typedef struct packed {
        logic              valids_0;
        logic              valids_1;
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] insts_0;
        logic [INST_W-1:0] insts_1;
        bp_pack_t          bp;
    } fetch_pack_t;

    localparam int FETCH_PACK_W = $bits(fetch_pack_t);

endpackage

// File: rtl/fetch_queue.sv
// Fetch queue: DEPTH-entry circular buffer of fetch packs between fetch and
// decode, with flush (redirect) and one-cycle enqueue-to-output latency.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 io_i_flush,

    input  logic                 io_i_fetch_pack_valid,
    output logic                 io_i_fetch_pack_ready,
    input  logic                 io_i_fetch_pack_bits_valids_0,
    input  logic                 io_i_fetch_pack_bits_valids_1,
    input  logic [XLEN-1:0]      io_i_fetch_pack_bits_pc,
    input  logic [INST_W-1:0]    io_i_fetch_pack_bits_insts_0,
    input  logic [INST_W-1:0]    io_i_fetch_pack_bits_insts_1,
    input  logic                 io_i_fetch_pack_bits_branch_predict_pack_valid,
    input  logic [XLEN-1:0]      io_i_fetch_pack_bits_branch_predict_pack_target,
    input  logic [BR_TYPE_W-1:0] io_i_fetch_pack_bits_branch_predict_pack_branch_type,
    input  logic                 io_i_fetch_pack_bits_branch_predict_pack_select,
    input  logic                 io_i_fetch_pack_bits_branch_predict_pack_taken,

    output logic                 io_o_fetch_pack_valid,
    input  logic                 io_o_fetch_pack_ready,
    output logic                 io_o_fetch_pack_bits_valids_0,
    output logic                 io_o_fetch_pack_bits_valids_1,
    output logic [XLEN-1:0]      io_o_fetch_pack_bits_pc,
    output logic [INST_W-1:0]    io_o_fetch_pack_bits_insts_0,
    output logic [INST_W-1:0]    io_o_fetch_pack_bits_insts_1,
    output logic                 io_o_fetch_pack_bits_branch_predict_pack_valid,
    output logic [XLEN-1:0]      io_o_fetch_pack_bits_branch_predict_pack_target,
    output logic [BR_TYPE_W-1:0] io_o_fetch_pack_bits_branch_predict_pack_branch_type,
    output logic                 io_o_fetch_pack_bits_branch_predict_pack_select,
    output logic                 io_o_fetch_pack_bits_branch_predict_pack_taken
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    fetch_pack_t      entry_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    fetch_pack_t pack_in;
    fetch_pack_t pack_out;
    logic        enq, deq;

    assign pack_in.valids_0       = io_i_fetch_pack_bits_valids_0;
    assign pack_in.valids_1       = io_i_fetch_pack_bits_valids_1;
    assign pack_in.pc             = io_i_fetch_pack_bits_pc;
    assign pack_in.insts_0        = io_i_fetch_pack_bits_insts_0;
    assign pack_in.insts_1        = io_i_fetch_pack_bits_insts_1;
    assign pack_in.bp.valid       = io_i_fetch_pack_bits_branch_predict_pack_valid;
    assign pack_in.bp.target      = io_i_fetch_pack_bits_branch_predict_pack_target;
    assign pack_in.bp.branch_type = io_i_fetch_pack_bits_branch_predict_pack_branch_type;
    assign pack_in.bp.select      = io_i_fetch_pack_bits_branch_predict_pack_select;
    assign pack_in.bp.taken       = io_i_fetch_pack_bits_branch_predict_pack_taken;

    // Ready depends only on occupancy, so a full queue never passes through
    // and a flush drops the incoming pack rather than stalling it.
    assign io_i_fetch_pack_ready = (count_q != FULL_CNT);
    assign io_o_fetch_pack_valid = (count_q != '0);

    assign enq = io_i_fetch_pack_valid & io_i_fetch_pack_ready & ~io_i_flush;
    assign deq = io_o_fetch_pack_valid & io_o_fetch_pack_ready & ~io_i_flush;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (io_i_flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) tail_d = tail_q + 1'b1;
            if (deq) head_d = head_q + 1'b1;
            case ({enq, deq})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (enq) entry_q[tail_q] <= pack_in;
        end
    end

    assign pack_out = entry_q[head_q];

    assign io_o_fetch_pack_bits_valids_0                        = pack_out.valids_0;
    assign io_o_fetch_pack_bits_valids_1                        = pack_out.valids_1;
    assign io_o_fetch_pack_bits_pc                              = pack_out.pc;
    assign io_o_fetch_pack_bits_insts_0                         = pack_out.insts_0;
    assign io_o_fetch_pack_bits_insts_1                         = pack_out.insts_1;
    assign io_o_fetch_pack_bits_branch_predict_pack_valid       = pack_out.bp.valid;
    assign io_o_fetch_pack_bits_branch_predict_pack_target      = pack_out.bp.target;
    assign io_o_fetch_pack_bits_branch_predict_pack_branch_type = pack_out.bp.branch_type;
    assign io_o_fetch_pack_bits_branch_predict_pack_select      = pack_out.bp.select;
    assign io_o_fetch_pack_bits_branch_predict_pack_taken       = pack_out.bp.taken;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus a random run, all checked
// against a queue-based model of the FIFO with flush and reset.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_rdy = 1'b0;
    fetch_pack_t in_pack = '0;
    logic        in_ready, out_valid;
    fetch_pack_t out_pack;

    fetch_pack_t model [$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_wrap = 0;
    int          m_tail = 0;

    always #5 clock = ~clock;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clock(clock),
        .reset(reset),
        .io_i_flush(flush),
        .io_i_fetch_pack_valid(in_valid),
        .io_i_fetch_pack_ready(in_ready),
        .io_i_fetch_pack_bits_valids_0(in_pack.valids_0),
        .io_i_fetch_pack_bits_valids_1(in_pack.valids_1),
        .io_i_fetch_pack_bits_pc(in_pack.pc),
        .io_i_fetch_pack_bits_insts_0(in_pack.insts_0),
        .io_i_fetch_pack_bits_insts_1(in_pack.insts_1),
        .io_i_fetch_pack_bits_branch_predict_pack_valid(in_pack.bp.valid),
        .io_i_fetch_pack_bits_branch_predict_pack_target(in_pack.bp.target),
        .io_i_fetch_pack_bits_branch_predict_pack_branch_type(in_pack.bp.branch_type),
        .io_i_fetch_pack_bits_branch_predict_pack_select(in_pack.bp.select),
        .io_i_fetch_pack_bits_branch_predict_pack_taken(in_pack.bp.taken),
        .io_o_fetch_pack_valid(out_valid),
        .io_o_fetch_pack_ready(out_rdy),
        .io_o_fetch_pack_bits_valids_0(out_pack.valids_0),
        .io_o_fetch_pack_bits_valids_1(out_pack.valids_1),
        .io_o_fetch_pack_bits_pc(out_pack.pc),
        .io_o_fetch_pack_bits_insts_0(out_pack.insts_0),
        .io_o_fetch_pack_bits_insts_1(out_pack.insts_1),
        .io_o_fetch_pack_bits_branch_predict_pack_valid(out_pack.bp.valid),
        .io_o_fetch_pack_bits_branch_predict_pack_target(out_pack.bp.target),
        .io_o_fetch_pack_bits_branch_predict_pack_branch_type(out_pack.bp.branch_type),
        .io_o_fetch_pack_bits_branch_predict_pack_select(out_pack.bp.select),
        .io_o_fetch_pack_bits_branch_predict_pack_taken(out_pack.bp.taken)
    );

    function automatic fetch_pack_t rand_pack();
        fetch_pack_t p;
        p.valids_0       = 1'($urandom);
        p.valids_1       = 1'($urandom);
        p.pc             = {$urandom, $urandom};
        p.insts_0        = $urandom;
        p.insts_1        = $urandom;
        p.bp.valid       = 1'($urandom);
        p.bp.target      = {$urandom, $urandom};
        p.bp.branch_type = 4'($urandom);
        p.bp.select      = 1'($urandom);
        p.bp.taken       = 1'($urandom);
        return p;
    endfunction

    // One clock: the model applies the FIFO rules to the inputs held across the edge.
    task automatic cycle();
        bit m_rdy, m_vld;
        m_rdy = model.size() < DEPTH;
        m_vld = model.size() != 0;
        @(posedge clock);
        if (flush) begin
            model.delete();
            m_tail = 0;
        end else begin
            if (out_rdy && m_vld) void'(model.pop_front());
            if (in_valid && m_rdy) begin
                model.push_back(in_pack);
                if (m_tail == DEPTH - 1) begin m_tail = 0; n_wrap++; end
                else m_tail++;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_pack !== '0) begin n_err++; $display("FAIL reset_bits: got %h want 0", out_pack); end
        @(posedge clock); #1;
        reset = 1'b0;
        model.delete();
        m_tail = 0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_single();
        fetch_pack_t p;
        p = '0;
        p.valids_0 = 1'b1; p.valids_1 = 1'b1;
        p.pc = 64'h0000_0000_8000_0000;
        p.insts_0 = 32'h0000_0013; p.insts_1 = 32'h0010_0093;
        in_pack = p; in_valid = 1'b1; out_rdy = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL single_ready_pre: got %b want 1", in_ready); end
        cycle();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_pack !== p) begin n_err++; $display("FAIL single_bits: got %h want %h", out_pack, p); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL single_ready_post: got %b want 1", in_ready); end
        out_rdy = 1'b1;
        cycle();
        out_rdy = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_fill_drain();
        fetch_pack_t pk [5];
        out_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pk[i] = rand_pack();
            in_pack = pk[i]; in_valid = 1'b1;
            n_cmp++; if (in_ready !== (i < 4)) begin n_err++; $display("FAIL fill_ready[%0d]: got %b want %b", i, in_ready, (i < 4)); end
            cycle();
        end
        in_valid = 1'b0;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fill_full: got %b want 0", in_ready); end
        n_cmp++; if (out_pack !== pk[0]) begin n_err++; $display("FAIL fill_hold: got %h want %h", out_pack, pk[0]); end
        out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (out_valid !== 1'b1 || out_pack !== pk[i]) begin n_err++; $display("FAIL drain_order[%0d]: got %b/%h want 1/%h", i, out_valid, out_pack, pk[i]); end
            cycle();
        end
        out_rdy = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty: got %b want 0", out_valid); end
    endtask

    task automatic test_full_simul();
        fetch_pack_t pk [4];
        fetch_pack_t x;
        fetch_pack_t exp_seq [4];
        out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pk[i] = rand_pack(); in_pack = pk[i]; in_valid = 1'b1;
            cycle();
        end
        x = rand_pack(); in_pack = x; in_valid = 1'b1; out_rdy = 1'b1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fullsim_ready_pre: got %b want 0", in_ready); end
        cycle();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fullsim_ready_next: got %b want 1", in_ready); end
        n_cmp++; if (out_pack !== pk[1]) begin n_err++; $display("FAIL fullsim_head: got %h want %h", out_pack, pk[1]); end
        out_rdy = 1'b0;
        cycle();
        in_valid = 1'b0;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fullsim_refull: got %b want 0", in_ready); end
        exp_seq[0] = pk[1]; exp_seq[1] = pk[2]; exp_seq[2] = pk[3]; exp_seq[3] = x;
        out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (out_valid !== 1'b1 || out_pack !== exp_seq[i]) begin n_err++; $display("FAIL fullsim_order[%0d]: got %b/%h want 1/%h", i, out_valid, out_pack, exp_seq[i]); end
            cycle();
        end
        out_rdy = 1'b0;
    endtask

    task automatic test_flush();
        fetch_pack_t d;
        out_rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_pack = rand_pack(); in_valid = 1'b1;
            cycle();
        end
        d = rand_pack(); d.pc = 64'hDEAD_BEEF_0000_1000;
        in_pack = d; in_valid = 1'b1; out_rdy = 1'b1; flush = 1'b1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready_during: got %b want 1", in_ready); end
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready_after: got %b want 1", in_ready); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_dropped[%0d]: valid %b pc %h want valid 0", i, out_valid, out_pack.pc); end
            cycle();
        end
        out_rdy = 1'b0;
    endtask

    task automatic test_random();
        int wraps0;
        wraps0 = n_wrap;
        for (int c = 0; c < 1000; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_pack  = rand_pack();
            out_rdy  = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 99) == 0);
            n_cmp++; if (in_ready !== (model.size() < DEPTH)) begin n_err++; $display("FAIL rand_ready[%0d]: got %b want %b", c, in_ready, (model.size() < DEPTH)); end
            n_cmp++; if (out_valid !== (model.size() != 0)) begin n_err++; $display("FAIL rand_valid[%0d]: got %b want %b", c, out_valid, (model.size() != 0)); end
            if (model.size() != 0) begin
                n_cmp++; if (out_pack !== model[0]) begin n_err++; $display("FAIL rand_bits[%0d]: got %h want %h", c, out_pack, model[0]); end
            end
            cycle();
        end
        flush = 1'b0; in_valid = 1'b0;
        out_rdy = 1'b1;
        for (int i = 0; i < DEPTH && model.size() != 0; i++) begin
            n_cmp++; if (out_pack !== model[0]) begin n_err++; $display("FAIL rand_tail_bits[%0d]: got %h want %h", i, out_pack, model[0]); end
            cycle();
        end
        out_rdy = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rand_final_empty: got %b want 0", out_valid); end
        n_cmp++; if (n_wrap - wraps0 < 100) begin n_err++; $display("FAIL rand_wraps: got %0d want >=100", n_wrap - wraps0); end
    endtask

    task automatic test_async_reset();
        out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_pack = rand_pack(); in_valid = 1'b1;
            cycle();
        end
        in_pack = rand_pack();
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL areset_pre_valid: got %b want 1", out_valid); end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL areset_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL areset_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_pack !== '0) begin n_err++; $display("FAIL areset_bits: got %h want 0", out_pack); end
        @(posedge clock); #1;
        in_valid = 1'b0;
        reset = 1'b0;
        model.delete();
        m_tail = 0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL areset_release: got valid %b ready %b want 0/1", out_valid, in_ready); end
        in_pack = rand_pack(); in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || out_pack !== model[0]) begin n_err++; $display("FAIL areset_reuse: got %b/%h want 1/%h", out_valid, out_pack, model[0]); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_full_simul();
        test_flush();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
